muskbus_line_engine: RTL and testbench
======================================

MUSKBUS_LINE_ENGINE -- requirements
Module: muskbus_line_engine

Interface
REQ-001 SHALL have parameter BID, default 1'b0, the bus id driven on bid.
REQ-002 SHALL have parameter BEATS, default 8, the number of 64-bit beats per 64-byte line.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid  input  1  client command present.
REQ-006 SHALL have port cmd_ready  output  1  engine accepts a command this cycle.
REQ-007 SHALL have port cmd_write  input  1  1 = line write, 0 = line read.
REQ-008 SHALL have port cmd_addr  input  64  byte address of the line.
REQ-009 SHALL have port cmd_wdata  input  512  write line; beat k = bits [64k+63:64k].
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  512  read line, valid when done follows a read.
REQ-012 SHALL have bus ports bid, req[63:0], reqtag[12:0], reqcyc and respack as outputs, and resp[63:0], respcyc and reqack as inputs, all 1 bit unless a width is given, matching the Muskbus Bottom modport.

Function
REQ-013 SHALL implement the states IDLE, RD_REQ, RD_RESP, WR_REQ, WR_DATA and DONE.
REQ-014 SHALL drive cmd_ready = 1 only in IDLE, and SHALL accept a command when cmd_valid && cmd_ready.
REQ-015 SHALL, on accept, latch cmd_addr with bits [5:0] forced to 0, latch cmd_wdata, clear the beat counter, and go to WR_REQ if cmd_write = 1, otherwise RD_REQ.
REQ-016 SHALL, in RD_REQ, drive reqcyc = 1, req = latched address and reqtag = {1'b1, 4'b0001, 8'h00}.
REQ-017 SHALL hold the RD_REQ outputs stable until reqack is sampled 1, then go to RD_RESP with reqcyc = 0 on the next cycle.
REQ-018 SHALL, in RD_RESP, drive respack = respcyc combinationally.
REQ-019 SHALL, on each cycle in RD_RESP with respcyc = 1, store resp into rdata beat slot [counter] and increment the counter.
REQ-020 SHALL leave RD_RESP for DONE on the cycle the BEATS-th beat is captured.
REQ-021 SHALL, in RD_RESP, skip capture and leave the counter unchanged on any cycle with respcyc = 0.
REQ-022 SHALL, in WR_REQ, drive reqcyc = 1, req = latched address and reqtag = {1'b0, 4'b0001, 8'h00}, and on reqack = 1 go to WR_DATA.
REQ-023 SHALL, in WR_DATA, drive reqcyc = 1 and req = wdata beat [counter], and SHALL advance the counter on each reqack = 1.
REQ-024 SHALL go from WR_DATA to DONE on the reqack of beat BEATS-1.
REQ-025 SHALL drive tag bits [7:0] as 8'h00 in WR_DATA.
REQ-026 SHALL, in DONE, drive done = 1 for exactly one cycle and then return to IDLE.
REQ-027 SHALL hold rdata until the next read capture.
REQ-028 SHALL ignore reqack whenever reqcyc = 0.
REQ-029 SHALL ignore respcyc outside RD_RESP and drive respack = 0 there.
REQ-030 SHALL ignore cmd_valid while not in IDLE.
REQ-031 SHALL drive bid = BID constantly.
REQ-032 SHALL use a counter of $clog2(BEATS)+1 bits and SHALL not wrap within a transaction.
REQ-033 SHALL transfer beat 0 first, at the lowest byte addresses.

Reset
REQ-034 SHALL, while reset_n = 0, asynchronously force state = IDLE, counter = 0, reqcyc = 0, respack = 0, done = 0, req = 0, reqtag = 0 and rdata = 0.
REQ-035 SHALL, on reset mid-transaction, discard partial data and issue no done.
REQ-036 SHALL have cmd_ready = 1 on the first clock edge after reset_n rises.

Verification
REQ-037 Read: cmd addr 0x1047, write = 0 -> req = 0x1040, reqtag = 0x1100 held until reqack; 8 beats of resp 0..7 -> rdata beat k = k, done pulses exactly once, respack mirrors respcyc.
REQ-038 Read with gaps: respcyc low for 3 cycles between beats 2 and 3 -> no capture and no respack during the gap, final rdata correct.
REQ-039 Write: wdata beat k = 0xA0+k, reqack delayed 2 cycles per beat -> tag 0x0100 with address, then req = 0xA0..0xA7 in order each held until its reqack, done after beat 7.
REQ-040 Back-to-back: cmd_valid held high -> second command accepted only in the IDLE cycle after done, cmd_ready low throughout the first transaction.
REQ-041 Reset during RD_RESP after 4 beats -> all outputs 0, no done; a subsequent read completes normally.
REQ-042 Spurious bus inputs: reqack and respcyc pulsed while IDLE -> no state change, respack = 0.

Source files
------------

// File: rtl/muskbus_line_engine.sv
// muskbus_line_engine: moves one 64-byte line across a Muskbus Bottom port as BEATS 64-bit beats.
module muskbus_line_engine #(
  parameter logic BID   = 1'b0,
  parameter int   BEATS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [63:0]           cmd_addr,
  input  logic [64*BEATS-1:0]   cmd_wdata,
  output logic                  done,
  output logic [64*BEATS-1:0]   rdata,
  output logic                  bid,
  output logic [63:0]           req,
  output logic [12:0]           reqtag,
  output logic                  reqcyc,
  output logic                  respack,
  input  logic [63:0]           resp,
  input  logic                  respcyc,
  input  logic                  reqack
);
  localparam int CW = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [12:0] TAG_RD = {1'b1, 4'b0001, 8'h00};
  localparam logic [12:0] TAG_WR = {1'b0, 4'b0001, 8'h00};
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_RESP, WR_REQ, WR_DATA, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [BEATS-1:0][63:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-2:0] idx;
  assign idx = cnt_q[CW-2:0];
  assign rdata = rdata_q;
  assign bid = BID;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr & ~64'h3f;
        wdata_d = cmd_wdata;
        cnt_d   = '0;
        state_d = cmd_write ? WR_REQ : RD_REQ;
      end
      RD_REQ:  state_d = reqack ? RD_RESP : RD_REQ;
      RD_RESP: if (respcyc) begin
        rdata_d[idx] = resp;
        cnt_d        = cnt_q + CW'(1);
        state_d      = (cnt_q == LAST) ? DONE : RD_RESP;
      end
      WR_REQ:  state_d = reqack ? WR_DATA : WR_REQ;
      WR_DATA: if (reqack) begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == LAST) ? DONE : WR_DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  // Bus outputs decode from state alone, so reset forcing IDLE also zeroes them.
  always_comb begin
    cmd_ready = state_q == IDLE;
    done      = state_q == DONE;
    reqcyc    = state_q inside {RD_REQ, WR_REQ, WR_DATA};
    respack   = (state_q == RD_RESP) && respcyc;
    req       = (state_q == WR_DATA) ? wdata_q[idx] :
                (state_q inside {RD_REQ, WR_REQ}) ? addr_q : '0;
    reqtag    = (state_q == RD_REQ) ? TAG_RD :
                (state_q inside {WR_REQ, WR_DATA}) ? TAG_WR : '0;
  end
endmodule

// File: tb/tb_muskbus_line_engine.sv
// tb_muskbus_line_engine: table-driven and randomized line transactions against a bus-side model.
module tb_muskbus_line_engine;
  localparam int BEATS = 8;
  logic clk = 0, reset_n = 1, cmd_valid = 0, cmd_write = 0, respcyc = 0, reqack = 0;
  logic [63:0] cmd_addr = '0, resp = '0;
  logic [511:0] cmd_wdata = '0;
  logic cmd_ready, done, bid, reqcyc, respack;
  logic [511:0] rdata, last_rd = '0;
  logic [63:0] req;
  logic [12:0] reqtag;
  int checks = 0, errors = 0;

  muskbus_line_engine #(.BID(1'b0), .BEATS(BEATS)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .done(done),
    .rdata(rdata), .bid(bid), .req(req), .reqtag(reqtag), .reqcyc(reqcyc),
    .respack(respack), .resp(resp), .respcyc(respcyc), .reqack(reqack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] exp_addr;
    logic [12:0] exp_tag;
    int          dly;
    int          gap_at;
    int          gap_len;
    int          gap_pct;
    bit          seq;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h exp %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_reqcyc"}, reqcyc, 0);
    chk({nm, "_respack"}, respack, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_req"}, req, 0);
    chk({nm, "_reqtag"}, reqtag, 0);
    chk({nm, "_ready"}, cmd_ready, 1);
    chk({nm, "_bid"}, bid, 0);
  endtask

  // Plays the bus slave for one line transaction and checks every cycle against the expected line.
  task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [63:0] exp_addr,
                         input logic [12:0] exp_tag, input int dly, input int gap_at,
                         input int gap_len, input int gap_pct, input bit seq, input bit hold);
    logic [511:0] wd, beats;
    logic rc;
    int k, n, g;
    for (int j = 0; j < BEATS; j++) begin
      wd[64*j +: 64]    = seq ? 64'(32'hA0 + j) : {$urandom, $urandom};
      beats[64*j +: 64] = seq ? 64'(j) : {$urandom, $urandom};
    end
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    #1 chk("accept_ready", cmd_ready, 1);
    tick;
    if (!hold) cmd_valid = 0;
    for (int i = 0; i <= dly; i++) begin
      reqack = (i == dly);
      #1;
      chk("req_addr", req, exp_addr);
      chk("req_tag", reqtag, exp_tag);
      chk("req_cyc", reqcyc, 1);
      chk("busy_ready", cmd_ready, 0);
      tick;
    end
    reqack = 0;
    if (!wr) begin
      k = 0; n = 0; g = 0;
      while (k < BEATS && n < 400) begin
        if (k == gap_at && g < gap_len) begin rc = 0; g++; end
        else rc = ($urandom_range(99) >= gap_pct);
        respcyc = rc;
        resp = rc ? beats[64*k +: 64] : {$urandom, $urandom};
        #1;
        chk("respack", respack, rc);
        chk("rd_reqcyc", reqcyc, 0);
        chk("rd_done", done, 0);
        tick;
        if (rc) k++;
        n++;
      end
      respcyc = 0;
      if (k < BEATS) chk("rd_timeout", k, BEATS);
    end else begin
      for (int b = 0; b < BEATS; b++) begin
        for (int i = 0; i <= dly; i++) begin
          reqack = (i == dly);
          #1;
          chk("wr_beat", req, wd[64*b +: 64]);
          chk("wr_cyc", reqcyc, 1);
          chk("wr_tag_lo", reqtag[7:0], 0);
          chk("wr_done", done, 0);
          tick;
        end
      end
      reqack = 0;
    end
    #1;
    chk("done", done, 1);
    chk("done_ready", cmd_ready, 0);
    if (!wr) last_rd = beats;
    chk("rdata", rdata, last_rd);
    tick;
    #1;
    chk("done_pulse", done, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("rdata_hold", rdata, last_rd);
  endtask

  initial begin
    tbl[0] = '{1'b0, 64'h1047, 64'h1040, 13'h1100, 2, -1, 0, 0, 1'b1};
    tbl[1] = '{1'b0, 64'h2000_0000_0000_0ABC, 64'h2000_0000_0000_0A80, 13'h1100, 0, 3, 3, 0, 1'b0};
    tbl[2] = '{1'b1, 64'h3F, 64'h0, 13'h0100, 2, -1, 0, 0, 1'b1};
    tbl[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0, 13'h0100, 0, -1, 0, 0, 1'b0};
    tbl[4] = '{1'b0, 64'h40, 64'h40, 13'h1100, 1, -1, 0, 50, 1'b0};

    #2 reset_n = 0;
    #1 chk_idle_outputs("reset");
    chk("reset_rdata", rdata, 0);
    tick; tick;
    reset_n = 1;
    tick;
    chk("ready_after_reset", cmd_ready, 1);

    for (int v = 0; v < 5; v++)
      run_txn(tbl[v].wr, tbl[v].addr, tbl[v].exp_addr, tbl[v].exp_tag, tbl[v].dly,
              tbl[v].gap_at, tbl[v].gap_len, tbl[v].gap_pct, tbl[v].seq, 1'b0);

    // Spurious bus inputs while idle must be ignored.
    reqack = 1; respcyc = 1; resp = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1 chk_idle_outputs("spurious");
      tick;
    end
    reqack = 0; respcyc = 0;
    chk("spurious_rdata", rdata, last_rd);

    // Back-to-back with cmd_valid held high across the first transaction.
    run_txn(1'b0, 64'h7777, 64'h7740, 13'h1100, 1, -1, 0, 20, 1'b0, 1'b1);
    run_txn(1'b1, 64'h8881, 64'h8880, 13'h0100, 1, -1, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of a read after four beats.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 64'h5000;
    tick;
    cmd_valid = 0; reqack = 1;
    tick;
    reqack = 0;
    for (int i = 0; i < 4; i++) begin
      respcyc = 1; resp = 64'(100 + i);
      tick;
    end
    #2 reset_n = 0;
    #1 chk_idle_outputs("midreset");
    chk("midreset_rdata", rdata, 0);
    last_rd = '0;
    respcyc = 0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("midreset_no_done", done, 0);
    end
    reset_n = 1;
    tick;
    chk("ready_after_midreset", cmd_ready, 1);
    chk("no_done_after_midreset", done, 0);
    run_txn(1'b0, 64'h5000, 64'h5000, 13'h1100, 0, -1, 0, 0, 1'b1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      logic wr;
      logic [63:0] a;
      wr = 1'($urandom_range(1));
      a = {$urandom, $urandom};
      run_txn(wr, a, {a[63:6], 6'b0}, wr ? 13'h0100 : 13'h1100, $urandom_range(3),
              -1, 0, 25, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
